// File: rtl/tap_window_mac_if.sv
// rtl/tap_window_mac_if.sv - tap input, coefficient write and result handshake bundle
interface tap_window_mac_if #(
  parameter int X  = 2,
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int OW = 16
);
  localparam int K  = 4 * X + 1;
  localparam int AW = $clog2(K);

  logic                     in_valid;
  logic                     in_ready;
  logic [X-1:0][DW-1:0]     out1;
  logic [X-1:0][DW-1:0]     out2;
  logic [X-1:0][DW-1:0]     out3;
  logic [X-1:0][DW-1:0]     out4;
  logic [DW-1:0]            out5;
  logic                     coef_wr_en;
  logic [AW-1:0]            coef_wr_addr;
  logic signed [CW-1:0]     coef_wr_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OW-1:0]     result;
  logic                     sat_flag;

  modport master (
    output in_valid, out1, out2, out3, out4, out5,
    output coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
    input  in_ready, out_valid, result, sat_flag
  );

  modport slave (
    input  in_valid, out1, out2, out3, out4, out5,
    input  coef_wr_en, coef_wr_addr, coef_wr_data, out_ready,
    output in_ready, out_valid, result, sat_flag
  );
endinterface

// File: rtl/tap_window_mac.sv
// rtl/tap_window_mac.sv - K-tap multiply-accumulate with saturation and credit-flowed output FIFO
module tap_window_mac #(
  parameter int X          = 2,
  parameter int DW         = 8,
  parameter int CW         = 8,
  parameter int OW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic             CLK,
  input logic             rst,
  tap_window_mac_if.slave bus
);
  localparam int K    = 4 * X + 1;
  localparam int PW   = DW + CW + 1;
  localparam int SW   = PW + $clog2(K);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (OW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-(2 ** (OW - 1)));

  logic [DW-1:0]        taps [K];
  logic signed [CW-1:0] coef_q [K];
  logic signed [CW-1:0] coef_d [K];
  logic signed [PW-1:0] prod_q [K];
  logic signed [PW-1:0] prod_d [K];
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic signed [OW-1:0] s2_q, s2_d;
  logic                 sat_q, sat_d;
  logic signed [OW-1:0] mem_q [FIFO_DEPTH];
  logic signed [OW-1:0] mem_d [FIFO_DEPTH];
  logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic signed [OW-1:0] result_q, result_d;
  logic signed [SW-1:0] sum;
  logic [CNTW:0]        credit_used;
  logic                 in_ready, accept, pop, clamp_hi, clamp_lo;

  always_comb begin
    for (int i = 0; i < X; i++) begin
      taps[4*i]     = bus.out1[i];
      taps[4*i + 1] = bus.out2[i];
      taps[4*i + 2] = bus.out3[i];
      taps[4*i + 3] = bus.out4[i];
    end
    taps[K-1] = bus.out5;
  end

  // Credits count every result already committed downstream, so a push can never find the FIFO full.
  assign credit_used = {1'b0, count_q} + {{CNTW{1'b0}}, v1_q} + {{CNTW{1'b0}}, v2_q};
  assign in_ready    = credit_used < (CNTW + 1)'(FIFO_DEPTH);
  assign accept      = bus.in_valid && in_ready;
  assign pop         = (count_q != '0) && bus.out_ready;

  always_comb begin
    coef_d = coef_q;
    if (bus.coef_wr_en && (int'(bus.coef_wr_addr) < K))
      coef_d[bus.coef_wr_addr] = bus.coef_wr_data;

    for (int t = 0; t < K; t++)
      prod_d[t] = accept ? PW'($signed({1'b0, taps[t]})) * PW'(coef_q[t]) : prod_q[t];
    v1_d = accept;

    sum = '0;
    for (int t = 0; t < K; t++)
      sum = sum + SW'(prod_q[t]);
    clamp_hi = sum > SAT_HI;
    clamp_lo = sum < SAT_LO;
    s2_d = s2_q;
    if (v1_q)
      s2_d = clamp_hi ? OW'(SAT_HI) : (clamp_lo ? OW'(SAT_LO) : OW'(sum));
    v2_d  = v1_q;
    sat_d = sat_q | (v1_q & (clamp_hi | clamp_lo));

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (v2_q) begin
      mem_d[wr_ptr_q] = s2_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    count_d  = count_q + CNTW'(v2_q) - CNTW'(pop);
    // Result is its own register so it holds the last head once the FIFO drains.
    result_d = (count_d != '0) ? mem_d[rd_ptr_d] : result_q;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int t = 0; t < K; t++) begin
        coef_q[t] <= '0;
        prod_q[t] <= '0;
      end
      for (int e = 0; e < FIFO_DEPTH; e++)
        mem_q[e] <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      s2_q     <= '0;
      sat_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      coef_q   <= coef_d;
      prod_q   <= prod_d;
      mem_q    <= mem_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      s2_q     <= s2_d;
      sat_q    <= sat_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (count_q != '0);
  assign bus.result    = result_q;
  assign bus.sat_flag  = sat_q;
endmodule
